// File: rtl/carfield_soc_fixture.sv
// carfield_soc_fixture
// Host-side boot/preload sequencer for the Carfield SoC. From the boot and
// preload modes it optionally streams a security-island (SECD) image and wakes
// SECD, streams the Cheshire image, writes the boot address, launches Cheshire,
// then polls the end-of-computation scratch register until bit 0 is set.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 one-cycle start pulse (honoured only in IDLE)
//   boot_mode_i             0 preload, 1 SD (unsupported), 2/3 autonomous
//   preload_mode_i          0 JTAG, 1 serial link, 2 UART, 3 reserved
//   secd_en_i               SECD image present
//   chs_entry_i             Cheshire entry address, latched at start
//   img_valid_i/img_ready_o image beat handshake
//   img_addr_i/img_data_i   beat target address / data
//   img_last_i              last beat of the current image
//   bus_req_o/bus_gnt_i     bus request / grant
//   bus_we_o, bus_addr_o, bus_wdata_o   request attributes
//   bus_rvalid_i/bus_rdata_i            read response
//   busy_o, done_o, error_o, exit_code_o status
//
// Optional feature: define CARFIELD_FIXTURE_TIMEOUT_EN to enable a watchdog
// that aborts polling to ERR (exit code 32'hFFFF_FFFF) after TimeoutCycles.
module carfield_soc_fixture #(
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          DataWidth     = 32,
  parameter logic [AddrWidth-1:0] SecdWakeAddr  = 48'h0_2040_0000,
  parameter logic [31:0]          SecdEntry     = 32'hE000_0080,
  parameter logic [AddrWidth-1:0] ChsBootAddr   = 48'h0_0300_0004,
  parameter logic [AddrWidth-1:0] ChsGoAddr     = 48'h0_0300_0000,
  parameter logic [AddrWidth-1:0] ScratchAddr   = 48'h0_0300_0008,
  parameter int unsigned          PollCycles    = 1024,
  parameter int unsigned          TimeoutCycles = 2**20
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           boot_mode_i,
  input  logic [1:0]           preload_mode_i,
  input  logic                 secd_en_i,
  input  logic [31:0]          chs_entry_i,
  input  logic                 img_valid_i,
  output logic                 img_ready_o,
  input  logic [AddrWidth-1:0] img_addr_i,
  input  logic [DataWidth-1:0] img_data_i,
  input  logic                 img_last_i,
  output logic                 bus_req_o,
  input  logic                 bus_gnt_i,
  output logic                 bus_we_o,
  output logic [AddrWidth-1:0] bus_addr_o,
  output logic [DataWidth-1:0] bus_wdata_o,
  input  logic                 bus_rvalid_i,
  input  logic [DataWidth-1:0] bus_rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [31:0]          exit_code_o
);

  typedef enum logic [3:0] {
    IDLE, LOAD_SECD, WAKE_SECD, LOAD_CHS, BOOT_ADDR, GO,
    POLL_WAIT, POLL_RD, DONE, ERR
  } state_e;

  state_e      state;
  logic        last_pend;  // last image beat issued, waiting for its grant
  logic        rd_wait;    // scratch read granted, waiting for rvalid
  logic [31:0] entry;
  logic [31:0] poll_cnt;
  logic        in_load;
  logic        beat_acc;

  assign in_load = (state == LOAD_SECD) || (state == LOAD_CHS);
  // A beat may be accepted in the same cycle the previous write is granted,
  // which keeps the request asserted with the new beat's address/data.
  assign img_ready_o = in_load && !last_pend && (!bus_req_o || bus_gnt_i);
  assign beat_acc    = img_valid_i && img_ready_o;

`ifdef CARFIELD_FIXTURE_TIMEOUT_EN
  logic [31:0] wd_cnt;
`else
  logic timeout_unused;
  assign timeout_unused = ^TimeoutCycles;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      last_pend   <= 1'b0;
      rd_wait     <= 1'b0;
      entry       <= '0;
      poll_cnt    <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      exit_code_o <= '0;
`ifdef CARFIELD_FIXTURE_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            entry <= chs_entry_i;
            if (boot_mode_i == 2'd1) begin
              state       <= ERR;
              done_o      <= 1'b1;
              error_o     <= 1'b1;
              exit_code_o <= 32'hBAD0_0001;
            end else if (boot_mode_i == 2'd0) begin
              if (preload_mode_i == 2'd3) begin
                state       <= ERR;
                done_o      <= 1'b1;
                error_o     <= 1'b1;
                exit_code_o <= 32'hBAD0_0003;
              end else begin
                busy_o <= 1'b1;
                // UART preload never carries a SECD image.
                state  <= (secd_en_i && preload_mode_i != 2'd2) ? LOAD_SECD : LOAD_CHS;
              end
            end else begin
              busy_o   <= 1'b1;
              poll_cnt <= '0;
              state    <= POLL_WAIT;
            end
          end
        end

        LOAD_SECD, LOAD_CHS: begin
          if (beat_acc) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b1;
            bus_addr_o  <= img_addr_i;
            bus_wdata_o <= img_data_i;
            last_pend   <= img_last_i;
          end else if (bus_req_o && bus_gnt_i) begin
            bus_req_o <= 1'b0;
            if (last_pend) begin
              last_pend <= 1'b0;
              state     <= (state == LOAD_SECD) ? WAKE_SECD : BOOT_ADDR;
            end
          end
        end

        WAKE_SECD, BOOT_ADDR, GO: begin
          if (!bus_req_o) begin
            bus_req_o <= 1'b1;
            bus_we_o  <= 1'b1;
            case (state)
              WAKE_SECD: begin
                bus_addr_o  <= SecdWakeAddr;
                bus_wdata_o <= DataWidth'(SecdEntry);
              end
              BOOT_ADDR: begin
                bus_addr_o  <= ChsBootAddr;
                bus_wdata_o <= DataWidth'(entry);
              end
              default: begin
                bus_addr_o  <= ChsGoAddr;
                bus_wdata_o <= DataWidth'(1);
              end
            endcase
          end else if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            case (state)
              WAKE_SECD: state <= LOAD_CHS;
              BOOT_ADDR: state <= GO;
              default: begin
                poll_cnt <= '0;
                state    <= POLL_WAIT;
              end
            endcase
          end
        end

        POLL_WAIT: begin
          if (poll_cnt == 32'(PollCycles - 1)) begin
            poll_cnt <= '0;
            state    <= POLL_RD;
          end else begin
            poll_cnt <= poll_cnt + 32'd1;
          end
        end

        POLL_RD: begin
          if (rd_wait) begin
            if (bus_rvalid_i) begin
              rd_wait <= 1'b0;
              if (bus_rdata_i[0]) begin
                exit_code_o <= {1'b0, bus_rdata_i[31:1]};
                busy_o      <= 1'b0;
                done_o      <= 1'b1;
                state       <= DONE;
              end else begin
                state <= POLL_WAIT;
              end
            end
          end else if (!bus_req_o) begin
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= ScratchAddr;
            bus_wdata_o <= '0;
          end else if (bus_gnt_i) begin
            bus_req_o <= 1'b0;
            rd_wait   <= 1'b1;
          end
        end

        default: ;  // DONE and ERR hold until reset
      endcase

`ifdef CARFIELD_FIXTURE_TIMEOUT_EN
      // Abort only when no request is pending so a held request is never
      // withdrawn before its grant.
      if (state == POLL_WAIT || state == POLL_RD) begin
        if (wd_cnt >= 32'(TimeoutCycles - 1) && !bus_req_o) begin
          state       <= ERR;
          rd_wait     <= 1'b0;
          busy_o      <= 1'b0;
          done_o      <= 1'b1;
          error_o     <= 1'b1;
          exit_code_o <= 32'hFFFF_FFFF;
        end else begin
          wd_cnt <= wd_cnt + 32'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_carfield_soc_fixture.sv
module tb_carfield_soc_fixture;
  localparam int          AW = 48;
  localparam int          DW = 32;
  localparam int          PC = 1024;
  localparam int          TO = 4096;
  localparam logic [47:0] SECD_WAKE  = 48'h0_2040_0000;
  localparam logic [31:0] SECD_ENTRY = 32'hE000_0080;
  localparam logic [47:0] CHS_BOOT   = 48'h0_0300_0004;
  localparam logic [47:0] CHS_GO     = 48'h0_0300_0000;
  localparam logic [47:0] SCRATCH    = 48'h0_0300_0008;

  logic          clk = 1'b0;
  logic          rst_i, start_i, secd_en_i, img_valid_i, img_ready_o, img_last_i;
  logic [1:0]    boot_mode_i, preload_mode_i;
  logic [31:0]   chs_entry_i;
  logic [AW-1:0] img_addr_i, bus_addr_o;
  logic [DW-1:0] img_data_i, bus_wdata_o, bus_rdata_i;
  logic          bus_req_o, bus_gnt_i, bus_we_o, bus_rvalid_i;
  logic          busy_o, done_o, error_o;
  logic [31:0]   exit_code_o;

  always #5 clk = ~clk;

  carfield_soc_fixture #(.TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .boot_mode_i(boot_mode_i),
    .preload_mode_i(preload_mode_i), .secd_en_i(secd_en_i), .chs_entry_i(chs_entry_i),
    .img_valid_i(img_valid_i), .img_ready_o(img_ready_o), .img_addr_i(img_addr_i),
    .img_data_i(img_data_i), .img_last_i(img_last_i), .bus_req_o(bus_req_o),
    .bus_gnt_i(bus_gnt_i), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .exit_code_o(exit_code_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard of expected bus transactions, in bus order.
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic          exp_we_q[$];
  logic [DW-1:0] scratch_q[$];
  bit            sb_en = 1'b1;
  int            gnt_delay = 0;
  int            rd_lat = 1;
  int            txn_cnt = 0;
  int            first_rd_cyc = -1;
  int            start_cyc = 0;

  // Bus responder: grants after gnt_delay idle cycles, answers reads rd_lat
  // cycles after the grant, and scores each transaction at its grant.
  int            wait_cnt = 0;
  int            rd_cnt = 0;
  bit            rd_pend = 1'b0;
  logic [AW-1:0] h_addr, e_addr;
  logic [DW-1:0] h_data, e_data;
  logic          h_we, e_we;

  always @(negedge clk) begin
    bus_gnt_i = 1'b0;
    bus_rvalid_i = 1'b0;
    if (rst_i) begin
      wait_cnt = 0;
      rd_pend = 1'b0;
    end else if (rd_pend) begin
      rd_cnt++;
      if (rd_cnt >= rd_lat) begin
        bus_rvalid_i = 1'b1;
        bus_rdata_i = (scratch_q.size() > 0) ? scratch_q.pop_front() : '0;
        rd_pend = 1'b0;
      end
    end else if (bus_req_o) begin
      if (wait_cnt == 0) begin
        h_addr = bus_addr_o; h_data = bus_wdata_o; h_we = bus_we_o;
        if (first_rd_cyc < 0 && !bus_we_o) first_rd_cyc = cyc;
      end else begin
        checks++;
        if ({bus_we_o, bus_addr_o, bus_wdata_o} !== {h_we, h_addr, h_data}) begin
          failures++;
          $display("FAIL bus_stable: got we=%0b addr=%h data=%h, held we=%0b addr=%h data=%h",
                   bus_we_o, bus_addr_o, bus_wdata_o, h_we, h_addr, h_data);
        end
      end
      if (wait_cnt >= gnt_delay) begin
        bus_gnt_i = 1'b1;
        wait_cnt = 0;
        txn_cnt++;
        if (!bus_we_o) begin rd_pend = 1'b1; rd_cnt = 0; end
        if (sb_en) begin
          checks++;
          if (exp_addr_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got we=%0b addr=%h data=%h, expected no transaction",
                     bus_we_o, bus_addr_o, bus_wdata_o);
          end else begin
            e_addr = exp_addr_q.pop_front(); e_data = exp_data_q.pop_front(); e_we = exp_we_q.pop_front();
            if (bus_we_o !== e_we || bus_addr_o !== e_addr || (e_we && bus_wdata_o !== e_data)) begin
              failures++;
              $display("FAIL sb_txn: got we=%0b addr=%h data=%h, expected we=%0b addr=%h data=%h",
                       bus_we_o, bus_addr_o, bus_wdata_o, e_we, e_addr, e_data);
            end
          end
        end
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic push_exp(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_we_q.push_back(we); exp_addr_q.push_back(a); exp_data_q.push_back(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; start_i = 1'b0; img_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    exp_addr_q.delete(); exp_data_q.delete(); exp_we_q.delete(); scratch_q.delete();
    gnt_delay = 0; rd_lat = 1; sb_en = 1'b1; first_rd_cyc = -1;
  endtask

  task automatic do_start(input logic [1:0] bm, input logic [1:0] pm, input logic se,
                          input logic [31:0] ent);
    @(negedge clk);
    boot_mode_i = bm; preload_mode_i = pm; secd_en_i = se; chs_entry_i = ent;
    start_i = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic l);
    bit acc = 1'b0;
    @(negedge clk);
    img_valid_i = 1'b1; img_addr_i = a; img_data_i = d; img_last_i = l;
    for (int n = 0; n < 200 && !acc; n++) begin
      #1;
      if (bus_req_o && bus_we_o && !bus_gnt_i) begin
        checks++;
        if (img_ready_o !== 1'b0) begin
          failures++;
          $display("FAIL ready_outstanding: img_ready_o=%0b, expected 0", img_ready_o);
        end
      end
      if (img_ready_o) begin
        @(posedge clk);
        acc = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL beat_accept: beat addr=%h not accepted, expected acceptance", a);
    end
  endtask

  task automatic end_beats();
    @(negedge clk);
    img_valid_i = 1'b0; img_last_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (done_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({busy_o, done_o, error_o, bus_req_o, img_ready_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%0b done=%0b err=%0b req=%0b ready=%0b, expected all 0",
               busy_o, done_o, error_o, bus_req_o, img_ready_o);
    end
    checks++;
    if (exit_code_o !== 32'h0 || bus_addr_o !== '0 || bus_wdata_o !== '0 || bus_we_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: exit=%h addr=%h wdata=%h we=%0b, expected 0",
               exit_code_o, bus_addr_o, bus_wdata_o, bus_we_o);
    end
  endtask

  task automatic test_secd_flow();
    bit ok;
    do_reset();
    push_exp(1, 48'h0_1000_0000, 32'h5EC0_0001);
    push_exp(1, 48'h0_1000_0004, 32'h5EC0_0002);
    push_exp(1, SECD_WAKE, SECD_ENTRY);
    for (int i = 0; i < 3; i++) push_exp(1, 48'h0_8000_0000 + 48'(4 * i), 32'hC500_0000 + 32'(i));
    push_exp(1, CHS_BOOT, 32'h8000_0000);
    push_exp(1, CHS_GO, 32'h1);
    push_exp(0, SCRATCH, 32'h0);
    push_exp(0, SCRATCH, 32'h0);
    scratch_q.push_back(32'h0); scratch_q.push_back(32'h1);
    do_start(2'd0, 2'd0, 1'b1, 32'h8000_0000);
    #1;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL secd_busy: busy=%0b done=%0b, expected busy=1 done=0", busy_o, done_o);
    end
    send_beat(48'h0_1000_0000, 32'h5EC0_0001, 1'b0);
    send_beat(48'h0_1000_0004, 32'h5EC0_0002, 1'b1);
    for (int i = 0; i < 3; i++) send_beat(48'h0_8000_0000 + 48'(4 * i), 32'hC500_0000 + 32'(i), i == 2);
    end_beats();
    wait_done(4000, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL secd_done_timeout: done_o=%0b, expected 1", done_o); end
    checks++;
    if (done_o !== 1'b1 || error_o !== 1'b0 || busy_o !== 1'b0 || exit_code_o !== 32'h0) begin
      failures++;
      $display("FAIL secd_result: done=%0b err=%0b busy=%0b exit=%h, expected 1 0 0 00000000",
               done_o, error_o, busy_o, exit_code_o);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL secd_sb_left: %0d transactions missing, expected 0", exp_addr_q.size());
    end
  endtask

  task automatic test_uart();
    bit ok;
    do_reset();
    push_exp(1, 48'h0_8000_1000, 32'hDEAD_BEEF);
    push_exp(1, CHS_BOOT, 32'h1234_5678);
    push_exp(1, CHS_GO, 32'h1);
    push_exp(0, SCRATCH, 32'h0);
    scratch_q.push_back(32'h0000_0007);
    do_start(2'd0, 2'd2, 1'b1, 32'h1234_5678);
    send_beat(48'h0_8000_1000, 32'hDEAD_BEEF, 1'b1);
    end_beats();
    wait_done(3000, ok);
    checks++;
    if (!ok || error_o !== 1'b0 || exit_code_o !== 32'h3) begin
      failures++;
      $display("FAIL uart_result: done=%0b err=%0b exit=%h, expected 1 0 00000003",
               done_o, error_o, exit_code_o);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL uart_sb_left: %0d transactions missing, expected 0", exp_addr_q.size());
    end
  endtask

  task automatic test_autonomous();
    bit ok;
    int lat;
    do_reset();
    push_exp(0, SCRATCH, 32'h0);
    scratch_q.push_back(32'h0000_0003);
    do_start(2'd2, 2'd0, 1'b1, 32'h0);
    wait_done(3000, ok);
    checks++;
    if (!ok || error_o !== 1'b0 || exit_code_o !== 32'h1) begin
      failures++;
      $display("FAIL auto_result: done=%0b err=%0b exit=%h, expected 1 0 00000001",
               done_o, error_o, exit_code_o);
    end
    lat = first_rd_cyc - (start_cyc + 1);
    checks++;
    if (first_rd_cyc < 0 || lat < PC || lat > PC + 2) begin
      failures++;
      $display("FAIL auto_poll_latency: got %0d cycles, expected %0d..%0d", lat, PC, PC + 2);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL auto_sb_left: %0d transactions missing, expected 0", exp_addr_q.size());
    end
  endtask

  task automatic test_errors();
    int t0;
    do_reset();
    t0 = txn_cnt;
    do_start(2'd1, 2'd0, 1'b0, 32'h0);
    #1;
    checks++;
    if (done_o !== 1'b1 || error_o !== 1'b1 || busy_o !== 1'b0 || exit_code_o !== 32'hBAD0_0001) begin
      failures++;
      $display("FAIL err_sd: done=%0b err=%0b busy=%0b exit=%h, expected 1 1 0 bad00001",
               done_o, error_o, busy_o, exit_code_o);
    end
    do_start(2'd0, 2'd3, 1'b0, 32'h0);
    repeat (10) @(negedge clk);
    checks++;
    if (error_o !== 1'b1 || exit_code_o !== 32'hBAD0_0001 || txn_cnt != t0) begin
      failures++;
      $display("FAIL err_sticky: err=%0b exit=%h txns=%0d, expected 1 bad00001 %0d",
               error_o, exit_code_o, txn_cnt, t0);
    end
    do_reset();
    do_start(2'd0, 2'd3, 1'b1, 32'h0);
    repeat (5) @(negedge clk);
    checks++;
    if (done_o !== 1'b1 || error_o !== 1'b1 || exit_code_o !== 32'hBAD0_0003 || txn_cnt != t0) begin
      failures++;
      $display("FAIL err_reserved: done=%0b err=%0b exit=%h txns=%0d, expected 1 1 bad00003 %0d",
               done_o, error_o, exit_code_o, txn_cnt, t0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    gnt_delay = 5; rd_lat = 3;
    push_exp(1, 48'h0_9000_0000, 32'h1111_0000);
    push_exp(1, 48'h0_9000_0004, 32'h2222_0000);
    push_exp(1, CHS_BOOT, 32'hA5A5_0000);
    push_exp(1, CHS_GO, 32'h1);
    push_exp(0, SCRATCH, 32'h0);
    scratch_q.push_back(32'h0000_0005);
    do_start(2'd0, 2'd1, 1'b0, 32'hA5A5_0000);
    send_beat(48'h0_9000_0000, 32'h1111_0000, 1'b0);
    send_beat(48'h0_9000_0004, 32'h2222_0000, 1'b1);
    end_beats();
    wait_done(3000, ok);
    checks++;
    if (!ok || error_o !== 1'b0 || exit_code_o !== 32'h2) begin
      failures++;
      $display("FAIL slow_result: done=%0b err=%0b exit=%h, expected 1 0 00000002",
               done_o, error_o, exit_code_o);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL slow_sb_left: %0d transactions missing, expected 0", exp_addr_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    int t0;
    do_reset();
    sb_en = 1'b0; gnt_delay = 5;
    do_start(2'd0, 2'd0, 1'b0, 32'h4000_0000);
    send_beat(48'h0_8000_2000, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    img_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus_req_o, img_ready_o, busy_o, done_o, error_o, bus_we_o} !== 6'b0 ||
        exit_code_o !== 32'h0 || bus_addr_o !== '0 || bus_wdata_o !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: req=%0b ready=%0b busy=%0b done=%0b err=%0b exit=%h addr=%h, expected 0",
               bus_req_o, img_ready_o, busy_o, done_o, error_o, exit_code_o, bus_addr_o);
    end
    rst_i = 1'b0;
    t0 = txn_cnt;
    repeat (20) @(negedge clk);
    checks++;
    if (bus_req_o !== 1'b0 || busy_o !== 1'b0 || txn_cnt != t0) begin
      failures++;
      $display("FAIL midreset_quiet: req=%0b busy=%0b txns=%0d, expected 0 0 %0d",
               bus_req_o, busy_o, txn_cnt, t0);
    end
  endtask

`ifdef CARFIELD_FIXTURE_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    do_reset();
    sb_en = 1'b0;
    do_start(2'd2, 2'd0, 1'b0, 32'h0);
    wait_done(TO + 2000, ok);
    checks++;
    if (!ok || error_o !== 1'b1 || busy_o !== 1'b0 || exit_code_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL timeout_result: done=%0b err=%0b busy=%0b exit=%h, expected 1 1 0 ffffffff",
               done_o, error_o, busy_o, exit_code_o);
    end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    sb_en = 1'b0;
    do_start(2'd2, 2'd0, 1'b0, 32'h0);
    repeat (TO + 1000) @(negedge clk);
    checks++;
    if (done_o !== 1'b0 || error_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL no_watchdog: done=%0b err=%0b busy=%0b, expected 0 0 1", done_o, error_o, busy_o);
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; start_i = 1'b0; boot_mode_i = '0; preload_mode_i = '0; secd_en_i = 1'b0;
    chs_entry_i = '0; img_valid_i = 1'b0; img_addr_i = '0; img_data_i = '0; img_last_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    test_reset();
    test_secd_flow();
    test_uart();
    test_autonomous();
    test_errors();
    test_back_to_back();
    test_reset_mid_load();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
